// File: rtl/axis_width_packer.sv
// axis_width_packer: packs RATIO narrow stream words into one wide beat with keep/last.
// Define AXIS_PACKER_FLUSH_EN to flush a partial beat after TIMEOUT idle cycles.
module axis_width_packer #(
  parameter int DATA_WIDTH = 5,
  parameter int RATIO      = 4,
  parameter int PKT_BEATS  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH*RATIO-1:0] data_o,
  output logic [RATIO-1:0]            keep_o,
  output logic                        last_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int LW = $clog2(RATIO);
  localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int WW = DATA_WIDTH * RATIO;
  localparam int AW = DATA_WIDTH * (RATIO - 1);
  localparam logic [LW-1:0] LANE_MAX = LW'(RATIO - 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(PKT_BEATS - 1);

  logic [LW-1:0] lane_q, lane_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [WW-1:0] data_q, data_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic last_q, last_d, valid_q, valid_d;
  logic in_hs, out_hs, out_free, complete, flush;

  // Only the word that completes a beat needs a free output register.
  assign out_free = ~valid_q | ready_i;
  assign ready_o  = (lane_q != LANE_MAX) | out_free;
  assign in_hs    = valid_i & ready_o;
  assign out_hs   = valid_q & ready_i;
  assign complete = in_hs & (lane_q == LANE_MAX);

`ifdef AXIS_PACKER_FLUSH_EN
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT - 1);
  logic [IW-1:0] idle_q;

  // Idle timer counts down to a saturating terminal count of zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q <= IDLE_LOAD;
    end else if (in_hs || (lane_q == '0)) begin
      idle_q <= IDLE_LOAD;
    end else if (idle_q != '0) begin
      idle_q <= idle_q - 1'b1;
    end
  end

  assign flush = (lane_q != '0) & (idle_q == '0) & ~valid_i & out_free;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    lane_d  = lane_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;

    // A beat flagged last (natural or flushed) restarts the packet count.
    if (out_hs) begin
      valid_d = 1'b0;
      beat_d  = (last_q || (beat_q == BEAT_MAX)) ? '0 : beat_q + 1'b1;
    end

    if (in_hs) begin
      if (complete) begin
        lane_d  = '0;
        data_d  = {data_i, acc_q};
        keep_d  = '1;
        last_d  = (beat_d == BEAT_MAX);
        valid_d = 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
        acc_d[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = data_i;
      end
    end else if (flush) begin
      lane_d  = '0;
      data_d  = '0;
      last_d  = 1'b1;
      valid_d = 1'b1;
      for (int k = 0; k < RATIO - 1; k++) begin
        if (k < int'(lane_q)) begin
          data_d[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      for (int k = 0; k < RATIO; k++) begin
        keep_d[k] = (k < int'(lane_q));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      beat_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_axis_width_packer.sv
// tb_axis_width_packer: directed vector table plus hand sequences for stall, packet, reset and flush.
module tb_axis_width_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic [19:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;

  int tests  = 0;
  int errors = 0;

  axis_width_packer #(
    .DATA_WIDTH(5), .RATIO(4), .PKT_BEATS(8), .TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .keep_o(keep_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        vi;
    logic [4:0]  di;
    logic        ri;
    logic        rdy;
    logic        vld;
    logic [19:0] dat;
    logic [3:0]  keep;
    logic        last;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vi, input logic [4:0] di, input logic ri,
                              input logic rdy, input logic vld, input logic [19:0] dat);
    vec_t v;
    v.vi = vi; v.di = di; v.ri = ri; v.rdy = rdy; v.vld = vld;
    v.dat = dat; v.keep = 4'hF; v.last = 1'b0;
    return v;
  endfunction

  function automatic logic [4:0] word(input int i, input int tag);
    return 5'((i * 7 + tag) % 32);
  endfunction

  // Streams n words back-to-back with ready_i=1 and checks every beat that emerges.
  task automatic stream(input int n, input int tag, input string nm);
    logic [19:0] exp_b[16];
    int got;
    logic rdy_ok;
    for (int j = 0; j < n / 4; j++) begin
      exp_b[j] = '0;
      for (int k = 0; k < 4; k++) exp_b[j][k*5 +: 5] = word(4 * j + k, tag);
    end
    got = 0;
    rdy_ok = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk_i); #1;
      valid_i = (i < n);
      data_i  = (i < n) ? word(i, tag) : 5'd0;
      #3;
      if ((i < n) && !ready_o) rdy_ok = 1'b0;
      if (valid_o) begin
        if (got < n / 4) begin
          check({nm, " data"}, 32'(data_o), 32'(exp_b[got]));
          check({nm, " keep"}, 32'(keep_o), 32'hF);
          check({nm, " last"}, 32'(last_o), 32'((got % 8) == 7));
        end
        got++;
      end
    end
    valid_i = 1'b0;
    check({nm, " beat count"}, 32'(got), 32'(n / 4));
    check({nm, " ready"}, 32'(rdy_ok), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    valid_i = 1'b0;
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    int seen;
    rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b1;

    #2;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset data_o", 32'(data_o), 32'd0);
    check("reset keep_o", 32'(keep_o), 32'd0);
    check("reset last_o", 32'(last_o), 32'd0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    #10 rst_ni = 1'b1;

    vecs[0]  = mk(1, 5'd1, 1, 1, 0, 20'h0);
    vecs[1]  = mk(1, 5'd2, 1, 1, 0, 20'h0);
    vecs[2]  = mk(1, 5'd3, 1, 1, 0, 20'h0);
    vecs[3]  = mk(1, 5'd4, 1, 1, 0, 20'h0);
    vecs[4]  = mk(0, 5'd0, 1, 1, 1, 20'h20C41);
    vecs[5]  = mk(0, 5'd0, 1, 1, 0, 20'h0);
    vecs[6]  = mk(1, 5'd5, 0, 1, 0, 20'h0);
    vecs[7]  = mk(1, 5'd6, 0, 1, 0, 20'h0);
    vecs[8]  = mk(1, 5'd7, 0, 1, 0, 20'h0);
    vecs[9]  = mk(1, 5'd8, 0, 1, 0, 20'h0);
    vecs[10] = mk(1, 5'd9, 0, 1, 1, 20'h41CC5);
    vecs[11] = mk(1, 5'd10, 0, 1, 1, 20'h41CC5);
    vecs[12] = mk(1, 5'd11, 0, 1, 1, 20'h41CC5);
    vecs[13] = mk(1, 5'd12, 0, 0, 1, 20'h41CC5);
    vecs[14] = mk(1, 5'd12, 0, 0, 1, 20'h41CC5);
    vecs[15] = mk(1, 5'd12, 0, 0, 1, 20'h41CC5);
    vecs[16] = mk(1, 5'd12, 1, 1, 1, 20'h41CC5);
    vecs[17] = mk(0, 5'd0, 1, 1, 1, 20'h62D49);
    vecs[18] = mk(0, 5'd0, 1, 1, 0, 20'h0);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk_i); #1;
      valid_i = vecs[i].vi; data_i = vecs[i].di; ready_i = vecs[i].ri;
      #3;
      check($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(vecs[i].rdy));
      check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vecs[i].vld));
      if (vecs[i].vld) begin
        check($sformatf("vec%0d data_o", i), 32'(data_o), 32'(vecs[i].dat));
        check($sformatf("vec%0d keep_o", i), 32'(keep_o), 32'(vecs[i].keep));
        check($sformatf("vec%0d last_o", i), 32'(last_o), 32'(vecs[i].last));
      end
    end

    do_reset();
    stream(64, 3, "packet");

    // Reset while three lanes are filled and a stalled beat is pending.
    ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_i); #1;
      valid_i = 1'b1; data_i = 5'(i + 20);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    #2;
    check("pre-reset valid_o", 32'(valid_o), 32'd1);
    check("pre-reset ready_o", 32'(ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    check("async reset valid_o", 32'(valid_o), 32'd0);
    check("async reset data_o", 32'(data_o), 32'd0);
    check("async reset keep_o", 32'(keep_o), 32'd0);
    check("async reset ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      valid_i = 1'b1; data_i = 5'(8'h11 + i);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      #3;
      if (valid_o) begin
        seen = 1;
        check("post-reset data_o", 32'(data_o), 32'hA4E51);
        check("post-reset keep_o", 32'(keep_o), 32'hF);
        check("post-reset last_o", 32'(last_o), 32'd0);
      end else begin
        @(posedge clk_i); #1;
      end
    end
    check("post-reset beat seen", 32'(seen), 32'd1);

`ifdef AXIS_PACKER_FLUSH_EN
    do_reset();
    ready_i = 1'b1;
    @(posedge clk_i); #1; valid_i = 1'b1; data_i = 5'h0A;
    @(posedge clk_i); #1; valid_i = 1'b1; data_i = 5'h0B;
    seen = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_i); #1; valid_i = 1'b0;
      #3;
      if (valid_o) seen++;
    end
    check("flush early beats", 32'(seen), 32'd0);
    @(posedge clk_i); #4;
    check("flush valid_o", 32'(valid_o), 32'd1);
    check("flush data_o", 32'(data_o), 32'h0016A);
    check("flush keep_o", 32'(keep_o), 32'h3);
    check("flush last_o", 32'(last_o), 32'd1);
    stream(32, 5, "after flush");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/axis_width_packer.md
# axis_width_packer

Stream width upsizer directly downstream of the ready/valid FIFO. It packs `RATIO` consecutive narrow words from the FIFO read port into one wide beat. It emits that beat on a ready/valid output with a lane-keep mask and a packet-end flag every `PKT_BEATS` beats. The block runs at full input throughput: one narrow word per cycle when the sink is not stalling.

## Interface
Parameters:
- `DATA_WIDTH`, default 5: width of one narrow input word.
- `RATIO`, default 4: narrow words per output beat. Must be ≥ 2.
- `PKT_BEATS`, default 8: output beats per packet. Must be ≥ 1.
- `TIMEOUT`, default 16: idle cycles before a partial flush. Must be ≥ 1. Used only when the flush feature is compiled in.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  input  1: clock.
- `rst_ni`  input  1: asynchronous active-low reset.
- `data_i`  input  `DATA_WIDTH`: narrow word from the FIFO `data_o`.
- `valid_i`  input  1: narrow word valid, from the FIFO `valid_o`.
- `ready_o`  output  1: block can accept a word; drives the FIFO `ready_i`.
- `data_o`  output  `DATA_WIDTH*RATIO`: wide beat. Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `keep_o`  output  `RATIO`: per-lane valid mask.
- `last_o`  output  1: final beat of a packet.
- `valid_o`  output  1: wide beat valid.
- `ready_i`  input  1: sink accepts the wide beat.

## Operation
- Input handshake: `in_hs = valid_i & ready_o`. Output handshake: `out_hs = valid_o & ready_i`.
- Storage:
  - Accumulator: `RATIO-1` lanes.
  - Lane counter `lane`: range 0..`RATIO-1`.
  - Output register: holds data, keep, last and valid.
- Lane order: the first accepted word goes to lane 0 (least significant). Later words fill ascending lanes.
- On `in_hs` with `lane < RATIO-1`: write the word to the accumulator at `lane`, then increment `lane`.
- On `in_hs` with `lane == RATIO-1`, all in the same edge:
  - load {`data_i`, accumulator} into the output register;
  - set `keep_o` to all ones and `valid_o` to 1;
  - set `lane` to 0.
- `ready_o` is combinational: `(lane != RATIO-1) | ~valid_o | ready_i`. A stalled sink therefore blocks only the word that completes a beat.
- Output register:
  - holds its contents stable while `valid_o & ~ready_i`;
  - clears `valid_o` on `out_hs` unless it reloads in the same edge.
- Beat counter `beat`, range 0..`PKT_BEATS-1`:
  - increments on `out_hs` and wraps to 0 after `PKT_BEATS-1`;
  - `last_o = (beat == PKT_BEATS-1)`, registered together with the beat's data.
- Reset (asynchronous, `rst_ni` low) clears `lane`, `beat`, the accumulator and the output register.
  - During reset: `valid_o`=0, `data_o`=0, `keep_o`=0, `last_o`=0.
  - `ready_o`=1 during reset, because `lane`=0.
  - A partially filled word is discarded. The first word after reset goes to lane 0.

## Timing
- Latency: the beat appears on `valid_o` in the cycle after the edge that accepts the `RATIO`-th word.
- Throughput: one narrow word per cycle sustained while `ready_i`=1.
- Simultaneous `out_hs` and beat completion in the same cycle: the old beat leaves and the new beat loads. `valid_o` stays 1 with no bubble.
- `ready_i` deasserted with the output register full and `lane == RATIO-1`: `ready_o` drops in the same cycle. The FIFO holds its word.
- `data_o`, `keep_o` and `last_o` must not change while `valid_o & ~ready_i`.

## Configuration
- Macro `AXIS_PACKER_FLUSH_EN`.
- When defined:
  - An idle counter runs while `lane != 0` and `in_hs`=0. It clears on any `in_hs` or when `lane` == 0.
  - Flush condition: counter == `TIMEOUT-1`, `valid_i`=0, and the output register is free (`~valid_o | ready_i`).
  - On flush, the next edge loads the partial word into the output register:
    - unfilled lanes are zero;
    - `keep_o` has ones for lanes 0..`lane-1`;
    - `last_o` is forced to 1.
  - In the same edge `lane` goes to 0. `beat` returns to 0 on that beat's `out_hs`.
  - If `valid_i` rises in the flush cycle, the input is accepted and the flush is cancelled.
- When undefined: no idle counter. A partial word waits indefinitely, and `keep_o` is all ones on every valid beat.

## Test plan
- Parameters `DATA_WIDTH`=5 and `RATIO`=4, `ready_i`=1, send 0x01, 0x02, 0x03, 0x04 back-to-back.
  - One cycle after the 4th accept: `valid_o`=1, `data_o`=20'h20C41, `keep_o`=4'hF.
- Send 8 words with `ready_i`=0 for 10 cycles.
  - Words 1–7 are accepted; `ready_o`=0 while the 8th word is presented.
  - The first beat is held stable.
  - After `ready_i`=1, the second beat follows one cycle after the first leaves, with no word lost.
- `PKT_BEATS`=8, `ready_i`=1, stream 64 words.
  - 16 beats out; `last_o`=1 only on beats 8 and 16.
- With `AXIS_PACKER_FLUSH_EN` and `TIMEOUT`=16, send 0x0A and 0x0B, then idle.
  - After 16 idle cycles: `valid_o`=1, `data_o`=20'h0016A, `keep_o`=4'b0011, `last_o`=1.
  - The next full beat has `last_o`=0 and beat count 0.
- Reset mid-operation: pull `rst_ni` low with 3 lanes filled and `valid_o`=1 stalled.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, 4 new words produce a beat containing only the new words.
